// File: rtl/dti_uart_pkg.sv
// rtl/dti_uart_pkg.sv - shared UART receive state type and oversampling constants
package dti_uart_pkg;

   localparam int CFG_DATA_WIDTH = 32;

   localparam int OS_RATE      = 16;
   localparam int OS_MID_FIRST = 7;
   localparam int OS_MID_LAST  = 9;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } rx_state_e;

endpackage

// File: rtl/rx_sample_sync.sv
// rtl/rx_sample_sync.sv - rx pin synchroniser with mid-bit sample history and majority vote
module rx_sample_sync
   import dti_uart_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic clken16_i,
   input  logic rx_i,
   output logic rx_s_o,
   output logic maj_o
);

   // History spans the earlier mid-bit samples; the current rx_s is the final vote.
   localparam int HIST = OS_MID_LAST - OS_MID_FIRST;

   logic            sync1_q;
   logic            sync2_q;
   logic [HIST-1:0] hist_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         hist_q  <= '1;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         if (clken16_i) begin
            hist_q <= {hist_q[HIST-2:0], sync2_q};
         end
      end
   end

   assign rx_s_o = sync2_q;
   assign maj_o  = (hist_q[1] & hist_q[0]) |
                   (hist_q[1] & sync2_q)   |
                   (hist_q[0] & sync2_q);

endmodule

// File: rtl/receiver.sv
// rtl/receiver.sv - UART receive engine: 16x oversampled start detect, data/parity/stop
// recovery, RX FIFO write and error pulses.
module receiver
   import dti_uart_pkg::*;
#(
   parameter int DATA_WIDTH     = CFG_DATA_WIDTH,
   parameter int DATA_BIT_WIDTH = 8,
   parameter int STOP_BIT_WIDTH = 1,
   parameter bit PARITY_EN      = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clken16,
   input  logic                  rx,
   input  logic                  rx_data_fifo_full,
   output logic                  rx_data_fifo_wr_req,
   output logic [DATA_WIDTH-1:0] rx_data_fifo_data_in,
   output logic                  rts_n,
   output logic                  rx_busy,
   output logic                  parity_err,
   output logic                  framing_err,
   output logic                  overrun_err
);

   localparam logic [3:0] OS_MID  = 4'(OS_MID_LAST);
   localparam logic [3:0] OS_WRAP = 4'(OS_RATE - 1);
   localparam logic [2:0] BIT_LAST  = 3'(DATA_BIT_WIDTH - 1);
   localparam logic       STOP_LAST = 1'(STOP_BIT_WIDTH - 1);

   logic rx_s;
   logic maj;

   rx_sample_sync u_sample (
      .clk       (clk),
      .reset_n   (reset_n),
      .clken16_i (clken16),
      .rx_i      (rx),
      .rx_s_o    (rx_s),
      .maj_o     (maj)
   );

   rx_state_e                 state_q;
   logic [3:0]                os_cnt_q;
   logic [2:0]                bitpos_q;
   logic                      stop_cnt_q;
   logic                      stop_bad_q;
   logic                      parity_bad_q;
   logic [DATA_BIT_WIDTH-1:0] shift_q;
   logic                      wr_req_q;
   logic [DATA_WIDTH-1:0]     data_q;
   logic                      parity_err_q;
   logic                      framing_err_q;
   logic                      overrun_err_q;
   logic                      rts_n_q;

   logic [3:0] os_cnt_d;
   logic       mid_d;
   logic       wrap_d;
   logic       frame_bad_d;
   logic       parity_bad_d;

   assign os_cnt_d     = os_cnt_q + 4'd1;
   assign mid_d        = (os_cnt_q == OS_MID);
   assign wrap_d       = (os_cnt_q == OS_WRAP);
   assign frame_bad_d  = stop_bad_q | ~maj;
   assign parity_bad_d = maj ^ (^shift_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         os_cnt_q      <= 4'd0;
         bitpos_q      <= 3'd0;
         stop_cnt_q    <= 1'b0;
         stop_bad_q    <= 1'b0;
         parity_bad_q  <= 1'b0;
         shift_q       <= '0;
         wr_req_q      <= 1'b0;
         data_q        <= '0;
         parity_err_q  <= 1'b0;
         framing_err_q <= 1'b0;
         overrun_err_q <= 1'b0;
         rts_n_q       <= 1'b1;
      end else begin
         wr_req_q      <= 1'b0;
         parity_err_q  <= 1'b0;
         framing_err_q <= 1'b0;
         overrun_err_q <= 1'b0;
         rts_n_q       <= rx_data_fifo_full;

         if (clken16) begin
            case (state_q)
               IDLE: begin
                  if (!rx_s) begin
                     state_q      <= START;
                     os_cnt_q     <= 4'd1;
                     bitpos_q     <= 3'd0;
                     stop_cnt_q   <= 1'b0;
                     stop_bad_q   <= 1'b0;
                     parity_bad_q <= 1'b0;
                  end
               end

               START: begin
                  os_cnt_q <= os_cnt_d;
                  if (mid_d && maj) begin
                     state_q  <= IDLE;
                     os_cnt_q <= 4'd0;
                  end else if (wrap_d) begin
                     state_q  <= DATA;
                     bitpos_q <= 3'd0;
                  end
               end

               DATA: begin
                  os_cnt_q <= os_cnt_d;
                  // Shift in from the top of the character so it ends right-aligned.
                  if (mid_d) begin
                     shift_q <= {maj, shift_q[DATA_BIT_WIDTH-1:1]};
                  end
                  if (wrap_d) begin
                     if (bitpos_q == BIT_LAST) begin
                        state_q    <= PARITY_EN ? PARITY : STOP;
                        stop_cnt_q <= 1'b0;
                     end else begin
                        bitpos_q <= bitpos_q + 3'd1;
                     end
                  end
               end

               PARITY: begin
                  os_cnt_q <= os_cnt_d;
                  if (mid_d) begin
                     parity_bad_q <= parity_bad_d;
                  end
                  if (wrap_d) begin
                     state_q    <= STOP;
                     stop_cnt_q <= 1'b0;
                  end
               end

               STOP: begin
                  os_cnt_q <= os_cnt_d;
                  // The last stop bit ends the frame at mid-bit so a slightly early
                  // next start edge is still caught from IDLE.
                  if (mid_d) begin
                     if (stop_cnt_q == STOP_LAST) begin
                        os_cnt_q      <= 4'd0;
                        state_q       <= frame_bad_d ? WAIT_HIGH : IDLE;
                        framing_err_q <= frame_bad_d;
                        overrun_err_q <= ~frame_bad_d & rx_data_fifo_full;
                        wr_req_q      <= ~frame_bad_d & ~rx_data_fifo_full;
                        parity_err_q  <= parity_bad_q;
                        if (!frame_bad_d && !rx_data_fifo_full) begin
                           data_q <= DATA_WIDTH'(shift_q);
                        end
                     end else begin
                        stop_bad_q <= frame_bad_d;
                     end
                  end else if (wrap_d) begin
                     stop_cnt_q <= stop_cnt_q + 1'b1;
                  end
               end

               WAIT_HIGH: begin
                  if (rx_s) begin
                     state_q <= IDLE;
                  end
               end

               default: begin
                  state_q  <= IDLE;
                  os_cnt_q <= 4'd0;
               end
            endcase
         end
      end
   end

   assign rx_data_fifo_wr_req  = wr_req_q;
   assign rx_data_fifo_data_in = data_q;
   assign rts_n                = rts_n_q;
   assign rx_busy              = (state_q != IDLE);
   assign parity_err           = parity_err_q;
   assign framing_err          = framing_err_q;
   assign overrun_err          = overrun_err_q;

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
- UART receive engine for dti_apb_uart. It is the serial-in counterpart of the transmit path.
- Synchronises the rx pin and detects the start bit using 16x oversampling.
- Recovers DATA_BIT_WIDTH data bits (LSB first), an optional even-parity bit, and stop bits.
- Pushes each good character into the RX data FIFO and flags parity, framing and overrun errors to the APB register block.

Parameters:
- DATA_WIDTH, `CFG_DATA_WIDTH: FIFO data width; the character is zero-extended to this width.
- DATA_BIT_WIDTH, 8: data bits per frame, legal range 5..8.
- STOP_BIT_WIDTH, 1: stop bits per frame, legal values 1..2.
- PARITY_EN, 0: 1 = one even-parity bit (XOR of the data bits) sits between the data and stop bits.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- clken16, input, 1: one-cycle enable at 16x the baud rate. All sampling and counting advance only on cycles where clken16=1.
- rx, input, 1: serial input, asynchronous to clk, idle high.
- rx_data_fifo_full, input, 1: RX FIFO full.
- rx_data_fifo_wr_req, output, 1: one-cycle write pulse.
- rx_data_fifo_data_in, output, DATA_WIDTH: received character, zero-extended.
- rts_n, output, 1: 0 = ready to receive; registered copy of rx_data_fifo_full.
- rx_busy, output, 1: 1 whenever the state is not IDLE.
- parity_err, output, 1: one-cycle pulse.
- framing_err, output, 1: one-cycle pulse.
- overrun_err, output, 1: one-cycle pulse.

Behaviour:
- Reset values:
  - state = IDLE; os_cnt = 0; bitpos = 0; shift register = 0.
  - rx synchroniser flops = 1.
  - rx_data_fifo_wr_req, parity_err, framing_err, overrun_err = 0; rx_data_fifo_data_in = 0.
  - rts_n = 1 (becomes rx_data_fifo_full one clk after reset release).
  - Reset mid-frame aborts the frame silently.
- Synchroniser: rx passes through 2 flops to give rx_s.
- Sampling: on each clken16 cycle, a 3-sample history of rx_s is kept. A bit value is the majority of the samples taken at os_cnt 7, 8 and 9, and is decided on the tick where os_cnt==9.
- os_cnt: 4-bit counter, wraps 15 to 0. The wrap marks a bit boundary.
- States and transitions (3-bit encoding):
  - IDLE: on a tick with rx_s==0, go to START with os_cnt=1. The detect tick counts as sample 0.
  - START: at os_cnt==9, if the majority is 1, this is a false start; return to IDLE with no flags. Otherwise continue; when os_cnt wraps, go to DATA with bitpos=0.
  - DATA: at os_cnt==9, shift the bit in LSB-first. At the wrap: if bitpos==DATA_BIT_WIDTH-1, go to PARITY (when PARITY_EN) or STOP; otherwise bitpos+1.
  - PARITY: at os_cnt==9, latch parity_bad = sample XOR (XOR of the data bits). At the wrap, go to STOP with stop count=0.
  - STOP: at os_cnt==9, sample the stop bit.
    - Not the last stop bit: continue to the wrap, then take the next stop bit.
    - Last stop bit: finish on this same tick and do not wait for the wrap. This allows back-to-back frames with up to 7/16 bit of skew.
  - Frame end when every stop bit sampled 1: go to IDLE.
  - Frame end when any stop bit sampled 0: go to WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with rx_s==1, then go to IDLE. This blocks false starts during a break.
- Frame completion (registered, asserted the clk cycle after the deciding tick):
  - Any stop bit sampled 0: framing_err=1. No FIFO write.
  - Else, rx_data_fifo_full=1: overrun_err=1. Character dropped, no write.
  - Else: rx_data_fifo_wr_req=1 and rx_data_fifo_data_in = character.
  - parity_err=1 whenever parity_bad, independent of the three cases above. A character with a parity error is still written if there is no framing error and no overrun.
- rx_data_fifo_data_in holds its value until the next write.
- Frame width with DATA_BIT_WIDTH<8: bits shift into the shift register from the MSB end of DATA_BIT_WIDTH, so the character appears right-aligned.
- clken16 low: all counters and states hold. The synchroniser still runs every clk.

Decomposition:
- Shared package dti_uart_pkg holds:
  - the rx_state_e enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - OS_RATE=16;
  - OS_MID_FIRST=7 and OS_MID_LAST=9.
- One sub-module, rx_sample_sync, contains the 2-flop synchroniser, the 3-tap history and the majority output.

Test Plan:
- 8N1, send 0xA5 at 16 ticks/bit, FIFO not full -> exactly one wr_req; data_in=0x000000A5; no error flags; rx_busy drops after the mid-stop-bit tick.
- 8E1 (PARITY_EN=1): send 0x3C with parity 0 -> written, no error. Send 0x3C with parity 1 -> written and parity_err pulses once.
- Glitch: rx low for 4 ticks then high -> returns to IDLE; no wr_req; no flags.
- Stop bit forced 0 on 0x55, then rx held low for 40 ticks -> framing_err pulse; no write; stays in WAIT_HIGH until rx high. The next 0x12 frame is received correctly.
- rx_data_fifo_full=1 during 0x7E -> overrun_err pulse; no wr_req; rts_n=1 one clk after full rises.
- Back-to-back frames 0x01, 0xFF with the second start edge 7 ticks early, plus reset_n pulsed mid-frame on a third frame -> first two frames written in order; after reset all outputs return to reset values with no spurious write.
